// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: default sample width and the
// measurement-stage state encoding.
package osc_pkg;

  localparam int DATA_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } stats_state_t;

endpackage

// File: rtl/stats_minmax_acc.sv
// Running max/min/sum datapath for one measurement window.
// init loads the first sample of a window, update folds in a further
// sample, clr zeroes the sum (max/min are simply overwritten by the next
// init). No sequencing lives here; the caller decides when to strobe.
module stats_minmax_acc #(
  parameter int DATA_W   = 12,
  parameter int WIN_LOG2 = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         init,
  input  logic                         update,
  input  logic [DATA_W-1:0]            sample,
  output logic [DATA_W-1:0]            run_max,
  output logic [DATA_W-1:0]            run_min,
  output logic [DATA_W+WIN_LOG2-1:0]   acc
);

  localparam int ACC_W = DATA_W + WIN_LOG2;

  logic [ACC_W-1:0] sample_ext_s;

  // Zero-extend the unsigned sample to accumulator width.
  always_comb begin
    sample_ext_s = {{WIN_LOG2{1'b0}}, sample};
  end

  // Running statistics: strict compares so ties keep the stored value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max <= {DATA_W{1'b0}};
      run_min <= {DATA_W{1'b0}};
      acc     <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc <= {ACC_W{1'b0}};
    end else if (init) begin
      run_max <= sample;
      run_min <= sample;
      acc     <= sample_ext_s;
    end else if (update) begin
      acc <= acc + sample_ext_s;
      if (sample > run_max) begin
        run_max <= sample;
      end
      if (sample < run_min) begin
        run_min <= sample;
      end
    end
  end

endmodule

// File: rtl/signal_stats.sv
// Windowed max/min/mean of the ADC stream for the on-screen text overlay.
// Outputs hold the last published window and change only at a commit.
// Optional build macro: STATS_PEAK_HOLD_EN turns max_bin/min_bin into
// peak-hold values (re-armed by reset or clear); mea_bin stays per-window.
module signal_stats
  import osc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int WIN_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              clear,
  input  logic              freeze,
  output logic [DATA_W-1:0] max_bin,
  output logic [DATA_W-1:0] min_bin,
  output logic [DATA_W-1:0] mea_bin,
  output logic              stats_valid
);

  localparam int ACC_W = DATA_W + WIN_LOG2;
  localparam logic [WIN_LOG2:0] CNT_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};
  localparam logic [WIN_LOG2:0] CNT_WIN  = CNT_ONE << WIN_LOG2;
  localparam logic [WIN_LOG2:0] CNT_LAST = CNT_WIN - CNT_ONE;
  // After the first sample a one-sample window is already complete.
  localparam stats_state_t FIRST_NEXT = (WIN_LOG2 == 0) ? DONE : ACCUM;

  stats_state_t        state_r;
  logic [WIN_LOG2:0]   count_r;
  logic                init_s;
  logic                update_s;
  logic [DATA_W-1:0]   run_max_s;
  logic [DATA_W-1:0]   run_min_s;
  logic [ACC_W-1:0]    acc_s;
`ifdef STATS_PEAK_HOLD_EN
  logic                reload_r;
`endif

  // Datapath strobes: a sample opens a window from IDLE or DONE, otherwise
  // it extends the current one; clear suppresses both.
  always_comb begin
    init_s   = 1'b0;
    update_s = 1'b0;
    if (!clear && sample_valid) begin
      if (state_r == ACCUM) begin
        update_s = 1'b1;
      end else begin
        init_s = 1'b1;
      end
    end else begin
      init_s   = 1'b0;
      update_s = 1'b0;
    end
  end

  stats_minmax_acc #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_minmax_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clear),
    .init    (init_s),
    .update  (update_s),
    .sample  (sample),
    .run_max (run_max_s),
    .run_min (run_min_s),
    .acc     (acc_s)
  );

  // Window FSM, sample counter and commit of the published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= {(WIN_LOG2+1){1'b0}};
      max_bin     <= {DATA_W{1'b0}};
      min_bin     <= {DATA_W{1'b0}};
      mea_bin     <= {DATA_W{1'b0}};
      stats_valid <= 1'b0;
`ifdef STATS_PEAK_HOLD_EN
      reload_r    <= 1'b1;
`endif
    end else begin
      stats_valid <= 1'b0;
      if (clear) begin
        state_r  <= IDLE;
        count_r  <= {(WIN_LOG2+1){1'b0}};
`ifdef STATS_PEAK_HOLD_EN
        reload_r <= 1'b1;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (sample_valid) begin
              count_r <= CNT_ONE;
              state_r <= FIRST_NEXT;
            end
          end
          ACCUM: begin
            if (sample_valid) begin
              count_r <= count_r + CNT_ONE;
              if (count_r == CNT_LAST) begin
                state_r <= DONE;
              end
            end
          end
          DONE: begin
            // The running values still describe the finished window here;
            // a concurrent sample only reaches them at this same edge.
            if (!freeze) begin
`ifdef STATS_PEAK_HOLD_EN
              max_bin  <= (reload_r || (run_max_s > max_bin)) ? run_max_s : max_bin;
              min_bin  <= (reload_r || (run_min_s < min_bin)) ? run_min_s : min_bin;
              reload_r <= 1'b0;
`else
              max_bin  <= run_max_s;
              min_bin  <= run_min_s;
`endif
              mea_bin     <= acc_s[ACC_W-1:WIN_LOG2];
              stats_valid <= 1'b1;
            end
            if (sample_valid) begin
              count_r <= CNT_ONE;
              state_r <= FIRST_NEXT;
            end else begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
            count_r <= {(WIN_LOG2+1){1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signal_stats.sv
// Directed bench for signal_stats with a 4-sample window.
module tb_signal_stats;

  logic        clk;
  logic        rst_n;
  logic [11:0] sample;
  logic        sample_valid;
  logic        clear;
  logic        freeze;
  logic [11:0] max_bin;
  logic [11:0] min_bin;
  logic [11:0] mea_bin;
  logic        stats_valid;

  int n_checks;
  int n_fail;
  int pulses;

  signal_stats #(
    .DATA_W   (12),
    .WIN_LOG2 (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .clear        (clear),
    .freeze       (freeze),
    .max_bin      (max_bin),
    .min_bin      (min_bin),
    .mea_bin      (mea_bin),
    .stats_valid  (stats_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count commit pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (stats_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic put(input logic [11:0] s, input logic clr);
    @(negedge clk);
    sample       = s;
    sample_valid = 1'b1;
    clear        = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      clear        = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    n_checks++; if (max_bin !== 12'd0) begin n_fail++; $display("FAIL reset_max: got %0d expected 0", max_bin); end
    n_checks++; if (min_bin !== 12'd0) begin n_fail++; $display("FAIL reset_min: got %0d expected 0", min_bin); end
    n_checks++; if (mea_bin !== 12'd0) begin n_fail++; $display("FAIL reset_mean: got %0d expected 0", mea_bin); end
    n_checks++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", stats_valid); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    int p0;
    p0 = pulses;
    put(12'd100, 1'b0); put(12'd200, 1'b0); put(12'd300, 1'b0); put(12'd400, 1'b0);
    idle(1);
    n_checks++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b expected 0", stats_valid); end
    n_checks++; if (max_bin !== 12'd0) begin n_fail++; $display("FAIL basic_early_max: got %0d expected 0", max_bin); end
    idle(1);
    n_checks++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", stats_valid); end
    n_checks++; if (max_bin !== 12'd400) begin n_fail++; $display("FAIL basic_max: got %0d expected 400", max_bin); end
    n_checks++; if (min_bin !== 12'd100) begin n_fail++; $display("FAIL basic_min: got %0d expected 100", min_bin); end
    n_checks++; if (mea_bin !== 12'd250) begin n_fail++; $display("FAIL basic_mean: got %0d expected 250", mea_bin); end
    idle(3);
    n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 1", pulses - p0); end
  endtask

  task automatic test_truncation;
    put(12'd7, 1'b0); put(12'd8, 1'b0); put(12'd8, 1'b0); put(12'd8, 1'b0);
    idle(2);
    n_checks++; if (max_bin !== 12'd8) begin n_fail++; $display("FAIL trunc_max: got %0d expected 8", max_bin); end
    n_checks++; if (min_bin !== 12'd7) begin n_fail++; $display("FAIL trunc_min: got %0d expected 7", min_bin); end
    n_checks++; if (mea_bin !== 12'd7) begin n_fail++; $display("FAIL trunc_mean: got %0d expected 7", mea_bin); end
    idle(2);
  endtask

  task automatic test_clear;
    put(12'd10, 1'b0); put(12'd20, 1'b0); put(12'd30, 1'b1);
    put(12'd40, 1'b0); put(12'd50, 1'b0); put(12'd60, 1'b0);
    n_checks++; if (max_bin !== 12'd8 || stats_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold1: got max %0d valid %0b expected max 8 valid 0", max_bin, stats_valid); end
    put(12'd70, 1'b0);
    n_checks++; if (max_bin !== 12'd8 || stats_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold2: got max %0d valid %0b expected max 8 valid 0", max_bin, stats_valid); end
    idle(1);
    n_checks++; if (mea_bin !== 12'd7 || stats_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold3: got mean %0d valid %0b expected mean 7 valid 0", mea_bin, stats_valid); end
    idle(1);
    n_checks++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL clear_valid: got %0b expected 1", stats_valid); end
    n_checks++; if (max_bin !== 12'd70) begin n_fail++; $display("FAIL clear_max: got %0d expected 70", max_bin); end
    n_checks++; if (min_bin !== 12'd40) begin n_fail++; $display("FAIL clear_min: got %0d expected 40", min_bin); end
    n_checks++; if (mea_bin !== 12'd55) begin n_fail++; $display("FAIL clear_mean: got %0d expected 55", mea_bin); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulses;
    put(12'd4095, 1'b0); put(12'd4095, 1'b0); put(12'd4095, 1'b0); put(12'd4095, 1'b0);
    put(12'd0, 1'b0); put(12'd0, 1'b0);
    n_checks++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %0b expected 1", stats_valid); end
    n_checks++; if (max_bin !== 12'd4095 || min_bin !== 12'd4095) begin n_fail++; $display("FAIL b2b_maxmin1: got %0d/%0d expected 4095/4095", max_bin, min_bin); end
    n_checks++; if (mea_bin !== 12'd4095) begin n_fail++; $display("FAIL b2b_mean1: got %0d expected 4095", mea_bin); end
    put(12'd0, 1'b0); put(12'd0, 1'b0);
    idle(2);
    n_checks++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %0b expected 1", stats_valid); end
    n_checks++; if (max_bin !== 12'd0 || min_bin !== 12'd0 || mea_bin !== 12'd0) begin n_fail++; $display("FAIL b2b_win2: got %0d/%0d/%0d expected 0/0/0", max_bin, min_bin, mea_bin); end
    idle(3);
    n_checks++; if (pulses - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0); end
  endtask

  task automatic test_freeze;
    int p0;
    p0 = pulses;
    freeze = 1'b1;
    put(12'd9, 1'b0); put(12'd9, 1'b0); put(12'd9, 1'b0); put(12'd9, 1'b0);
    idle(3);
    n_checks++; if (max_bin !== 12'd0 || min_bin !== 12'd0 || mea_bin !== 12'd0) begin n_fail++; $display("FAIL freeze_hold: got %0d/%0d/%0d expected 0/0/0", max_bin, min_bin, mea_bin); end
    n_checks++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL freeze_pulses: got %0d expected 0", pulses - p0); end
    freeze = 1'b0;
    put(12'd1, 1'b0); put(12'd2, 1'b0); put(12'd3, 1'b0); put(12'd4, 1'b0);
    idle(2);
    n_checks++; if (stats_valid !== 1'b1) begin n_fail++; $display("FAIL freeze_valid: got %0b expected 1", stats_valid); end
    n_checks++; if (max_bin !== 12'd4 || min_bin !== 12'd1 || mea_bin !== 12'd2) begin n_fail++; $display("FAIL freeze_next: got %0d/%0d/%0d expected 4/1/2", max_bin, min_bin, mea_bin); end
    idle(2);
  endtask

  task automatic test_peak_hold;
    logic [11:0] exp_max;
`ifdef STATS_PEAK_HOLD_EN
    exp_max = 12'd500;
`else
    exp_max = 12'd300;
`endif
    @(negedge clk); clear = 1'b1; sample_valid = 1'b0;
    idle(1);
    put(12'd500, 1'b0); put(12'd500, 1'b0); put(12'd500, 1'b0); put(12'd500, 1'b0);
    put(12'd300, 1'b0); put(12'd300, 1'b0);
    n_checks++; if (max_bin !== 12'd500 || min_bin !== 12'd500 || mea_bin !== 12'd500) begin n_fail++; $display("FAIL peak_first: got %0d/%0d/%0d expected 500/500/500", max_bin, min_bin, mea_bin); end
    put(12'd300, 1'b0); put(12'd300, 1'b0);
    idle(2);
    n_checks++; if (max_bin !== exp_max) begin n_fail++; $display("FAIL peak_max: got %0d expected %0d", max_bin, exp_max); end
    n_checks++; if (min_bin !== 12'd300) begin n_fail++; $display("FAIL peak_min: got %0d expected 300", min_bin); end
    n_checks++; if (mea_bin !== 12'd300) begin n_fail++; $display("FAIL peak_mean: got %0d expected 300", mea_bin); end
    idle(1);
  endtask

  task automatic test_async_reset;
    put(12'd11, 1'b0); put(12'd12, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (max_bin !== 12'd0 || min_bin !== 12'd0 || mea_bin !== 12'd0) begin n_fail++; $display("FAIL async_reset_out: got %0d/%0d/%0d expected 0/0/0", max_bin, min_bin, mea_bin); end
    n_checks++; if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %0b expected 0", stats_valid); end
    idle(2);
    rst_n = 1'b1;
    put(12'd20, 1'b0); put(12'd40, 1'b0); put(12'd60, 1'b0); put(12'd80, 1'b0);
    idle(2);
    n_checks++; if (max_bin !== 12'd80 || min_bin !== 12'd20 || mea_bin !== 12'd50) begin n_fail++; $display("FAIL async_reset_after: got %0d/%0d/%0d expected 80/20/50", max_bin, min_bin, mea_bin); end
    idle(1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    pulses       = 0;
    rst_n        = 1'b0;
    sample       = 12'd0;
    sample_valid = 1'b0;
    clear        = 1'b0;
    freeze       = 1'b0;
    test_reset();
    test_basic();
    test_truncation();
    test_clear();
    test_back_to_back();
    test_freeze();
    test_peak_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
